// File: rtl/game_ctrl.sv
// Game-flow controller: sequences title/staff/stage/success/fail screens and
// owns every status field the overlay renderer draws.
module game_ctrl #(
  parameter int KEYS_NEEDED = 3,
  parameter int START_HEART = 3,
  parameter int INV_CYCLES  = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel_stage,
  input  logic       btn_sel,
  input  logic       btn_next,
  input  logic       btn_back,
  input  logic       btn_retry,
  input  logic       btn_staff,
  input  logic       key_pick,
  input  logic       light_pick,
  input  logic       door_reach,
  input  logic       hit,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] heart,
  output logic [1:0] todo,
  output logic [3:0] play_valid
);

  typedef enum logic [3:0] {
    S_TITLE    = 4'd0,
    S_STAFF    = 4'd1,
    S_STAGE1   = 4'd2,
    S_SUCCESS1 = 4'd3,
    S_STAGE2   = 4'd4,
    S_SUCCESS2 = 4'd5,
    S_STAGE3   = 4'd6,
    S_SUCCESS3 = 4'd7,
    S_FAIL     = 4'd8
  } state_e;

  localparam logic [1:0]  TD_NONE  = 2'd0;
  localparam logic [1:0]  TD_KEY   = 2'd1;
  localparam logic [1:0]  TD_LIGHT = 2'd2;
  localparam logic [1:0]  TD_DOOR  = 2'd3;
  localparam logic [1:0]  KEYS     = 2'(KEYS_NEEDED);
  localparam logic [1:0]  HEART0   = 2'(START_HEART);
  localparam logic [24:0] INV_LOAD = 25'(INV_CYCLES - 1);

  state_e      state_q, state_d, last_q, last_d, enter_st;
  logic [1:0]  key_q, key_d, heart_q, heart_d, todo_q, todo_d;
  logic [3:0]  pv_q, pv_d;
  logic [24:0] inv_q, inv_d;
  logic        enter, go_title;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_TITLE;
      last_q  <= S_STAGE1;
      key_q   <= 2'd0;
      heart_q <= HEART0;
      todo_q  <= TD_NONE;
      pv_q    <= 4'b0011;
      inv_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      key_q   <= key_d;
      heart_q <= heart_d;
      todo_q  <= todo_d;
      pv_q    <= pv_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    key_d    = key_q;
    heart_d  = heart_q;
    todo_d   = todo_q;
    pv_d     = pv_q;
    inv_d    = (inv_q != '0) ? inv_q - 25'd1 : '0;
    enter    = 1'b0;
    enter_st = S_STAGE1;
    go_title = 1'b0;

    case (state_q)
      S_TITLE: begin
        go_title = 1'b1;
        if (btn_sel) begin
          if (sel_stage != 2'd0 && pv_q[sel_stage]) begin
            enter = 1'b1;
            case (sel_stage)
              2'd1:    enter_st = S_STAGE1;
              2'd2:    enter_st = S_STAGE2;
              default: enter_st = S_STAGE3;
            endcase
          end
        end else if (btn_staff) begin
          go_title = 1'b0;
          state_d  = S_STAFF;
          key_d    = 2'd0;
          heart_d  = HEART0;
          todo_d   = TD_NONE;
        end
      end
      S_STAFF: begin
        key_d   = 2'd0;
        heart_d = HEART0;
        todo_d  = TD_NONE;
        if (btn_back) go_title = 1'b1;
      end
      S_STAGE1, S_STAGE2, S_STAGE3: begin
        if (btn_back) begin
          go_title = 1'b1;
        end else begin
          // All qualifications look at todo_q, so only one progress step per cycle
          if (key_pick && todo_q == TD_KEY) begin
            key_d = key_q + 2'd1;
            if (key_q + 2'd1 == KEYS) todo_d = TD_LIGHT;
          end
          if (light_pick && todo_q == TD_LIGHT) todo_d = TD_DOOR;
          if (hit && inv_q == '0) begin
            heart_d = heart_q - 2'd1;
            inv_d   = INV_LOAD;
          end
          if (heart_d == 2'd0) begin
            state_d = S_FAIL;
            todo_d  = TD_NONE;
          end else if (door_reach && todo_q == TD_DOOR) begin
            todo_d = TD_NONE;
            case (state_q)
              S_STAGE1: begin state_d = S_SUCCESS1; pv_d[2] = 1'b1; end
              S_STAGE2: begin state_d = S_SUCCESS2; pv_d[3] = 1'b1; end
              default:  state_d = S_SUCCESS3;
            endcase
          end
        end
      end
      S_SUCCESS1, S_SUCCESS2, S_SUCCESS3: begin
        todo_d = TD_NONE;
        if (btn_back) begin
          go_title = 1'b1;
        end else if (btn_next) begin
          case (state_q)
            S_SUCCESS1: begin enter = 1'b1; enter_st = S_STAGE2; end
            S_SUCCESS2: begin enter = 1'b1; enter_st = S_STAGE3; end
            default: begin
              state_d = S_STAFF;
              key_d   = 2'd0;
              heart_d = HEART0;
            end
          endcase
        end
      end
      S_FAIL: begin
        heart_d = 2'd0;
        todo_d  = TD_NONE;
        if (btn_retry) begin
          enter    = 1'b1;
          enter_st = last_q;
        end else if (btn_back) begin
          go_title = 1'b1;
        end
      end
      default: go_title = 1'b1;
    endcase

    if (go_title) begin
      state_d = S_TITLE;
      key_d   = 2'd0;
      heart_d = HEART0;
      todo_d  = TD_NONE;
    end
    if (enter) begin
      state_d = enter_st;
      last_d  = enter_st;
      key_d   = 2'd0;
      heart_d = HEART0;
      todo_d  = TD_KEY;
      inv_d   = '0;
    end
  end

  assign state      = state_q;
  assign key_find   = key_q;
  assign heart      = heart_q;
  assign todo       = todo_q;
  assign play_valid = pv_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table, hand sequences for the timing
// corners, then random pulses checked against a rule-level model.
module tb_game_ctrl;
  localparam int KN = 3;
  localparam int SH = 3;
  localparam int IC = 8;

  typedef struct packed {
    logic [1:0] sel;
    logic bsel, bnext, bback, bretry, bstaff, key, light, door, hit;
  } in_t;

  typedef struct {
    in_t i;
    int  gap;
    int  st, kf, ht, td, pv;
  } vec_t;

  localparam logic [10:0] I_SEL = 11'h100, I_NEXT = 11'h080, I_BACK = 11'h040,
    I_RETRY = 11'h020, I_STAFF = 11'h010, I_KEY = 11'h008, I_LIGHT = 11'h004,
    I_DOOR = 11'h002, I_HIT = 11'h001;

  logic clk, rst_n;
  in_t  v;
  logic [3:0] state, play_valid;
  logic [1:0] key_find, heart, todo;

  int checks = 0, errors = 0;
  int m_state, m_key, m_heart, m_todo, m_last, m_inv;
  logic [3:0] m_pv;

  game_ctrl #(.KEYS_NEEDED(KN), .START_HEART(SH), .INV_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n), .sel_stage(v.sel), .btn_sel(v.bsel),
    .btn_next(v.bnext), .btn_back(v.bback), .btn_retry(v.bretry),
    .btn_staff(v.bstaff), .key_pick(v.key), .light_pick(v.light),
    .door_reach(v.door), .hit(v.hit), .state(state), .key_find(key_find),
    .heart(heart), .todo(todo), .play_valid(play_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic expect5(input string n, input int st, kf, ht, td, pv);
    check({n, ".state"}, int'(state), st);
    check({n, ".key_find"}, int'(key_find), kf);
    check({n, ".heart"}, int'(heart), ht);
    check({n, ".todo"}, int'(todo), td);
    check({n, ".play_valid"}, int'(play_valid), pv);
  endtask

  task automatic model_reset();
    m_state = 0; m_key = 0; m_heart = SH; m_todo = 0; m_pv = 4'b0011;
    m_last = 2; m_inv = 0;
  endtask

  // Rule-level model: one call per clock edge with that cycle's pulses.
  task automatic model_step(input in_t p);
    int ns, inv_n, es, todo0;
    bit ent;
    ns = m_state; ent = 0; es = 0; todo0 = m_todo;
    inv_n = (m_inv > 0) ? m_inv - 1 : 0;
    if (m_state == 0) begin
      if (p.bsel) begin
        if (p.sel != 0 && m_pv[p.sel]) begin ent = 1; es = 2 * int'(p.sel); end
      end else if (p.bstaff) ns = 1;
    end else if (m_state == 1) begin
      if (p.bback) ns = 0;
    end else if (m_state == 2 || m_state == 4 || m_state == 6) begin
      if (p.bback) ns = 0;
      else begin
        if (p.key && todo0 == 1) begin
          m_key++;
          if (m_key == KN) m_todo = 2;
        end
        if (p.light && todo0 == 2) m_todo = 3;
        if (p.hit && m_inv == 0) begin m_heart--; inv_n = IC - 1; end
        if (m_heart == 0) begin ns = 8; m_todo = 0; end
        else if (p.door && todo0 == 3) begin
          ns = m_state + 1; m_todo = 0;
          if (m_state == 2) m_pv[2] = 1'b1;
          if (m_state == 4) m_pv[3] = 1'b1;
        end
      end
    end else if (m_state == 3 || m_state == 5 || m_state == 7) begin
      if (p.bback) ns = 0;
      else if (p.bnext) begin
        if (m_state == 7) ns = 1;
        else begin ent = 1; es = m_state + 1; end
      end
    end else begin
      if (p.bretry) begin ent = 1; es = m_last; end
      else if (p.bback) ns = 0;
    end
    m_inv = inv_n;
    if (ns <= 1) begin m_key = 0; m_heart = SH; m_todo = 0; end
    if (ent) begin
      ns = es; m_last = es; m_key = 0; m_heart = SH; m_todo = 1; m_inv = 0;
    end
    m_state = ns;
  endtask

  task automatic cyc(input in_t p);
    @(negedge clk);
    v = p;
    @(posedge clk);
    #1;
    model_step(p);
    expect5("model", m_state, m_key, m_heart, m_todo, int'(m_pv));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(in_t'(11'h0));
  endtask

  task automatic pulse(input logic [10:0] b, input string n, input int st, kf, ht, td, pv);
    cyc(in_t'(b));
    expect5(n, st, kf, ht, td, pv);
  endtask

  vec_t tbl[];

  initial begin
    v = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    expect5("reset", 0, 0, 3, 0, 3);
    @(negedge clk);
    rst_n = 1'b1;

    tbl = new[14];
    tbl[0]  = '{in_t'(I_STAFF), 0, 1, 0, 3, 0, 3};
    tbl[1]  = '{in_t'(I_BACK), 0, 0, 0, 3, 0, 3};
    tbl[2]  = '{in_t'(I_SEL | (11'd3 << 9)), 0, 0, 0, 3, 0, 3};
    tbl[3]  = '{in_t'(I_SEL), 0, 0, 0, 3, 0, 3};
    tbl[4]  = '{in_t'(I_SEL | (11'd2 << 9)), 0, 0, 0, 3, 0, 3};
    tbl[5]  = '{in_t'(I_SEL | (11'd1 << 9)), 0, 2, 0, 3, 1, 3};
    tbl[6]  = '{in_t'(I_KEY), 10, 2, 1, 3, 1, 3};
    tbl[7]  = '{in_t'(I_KEY), 10, 2, 2, 3, 1, 3};
    tbl[8]  = '{in_t'(I_KEY | I_LIGHT), 10, 2, 3, 3, 2, 3};
    tbl[9]  = '{in_t'(I_KEY), 0, 2, 3, 3, 2, 3};
    tbl[10] = '{in_t'(I_DOOR), 0, 2, 3, 3, 2, 3};
    tbl[11] = '{in_t'(I_LIGHT), 0, 2, 3, 3, 3, 3};
    tbl[12] = '{in_t'(I_DOOR), 0, 3, 3, 3, 0, 7};
    tbl[13] = '{in_t'(I_NEXT), 0, 4, 0, 3, 1, 7};
    for (int i = 0; i < tbl.size(); i++) begin
      idle(tbl[i].gap);
      cyc(tbl[i].i);
      expect5($sformatf("vec%0d", i), tbl[i].st, tbl[i].kf, tbl[i].ht, tbl[i].td, tbl[i].pv);
    end

    // Invulnerability window: second hit lands inside it, third just after
    pulse(I_HIT, "hit0", 4, 0, 2, 1, 7);
    idle(3);
    pulse(I_HIT, "hit4", 4, 0, 2, 1, 7);
    idle(3);
    pulse(I_HIT, "hit8", 4, 0, 1, 1, 7);
    idle(9);
    pulse(I_HIT, "hit_fatal", 8, 0, 0, 0, 7);
    pulse(I_RETRY, "retry", 4, 0, 3, 1, 7);

    // Fatal hit beats same-cycle door
    pulse(I_KEY, "b.k1", 4, 1, 3, 1, 7);
    pulse(I_KEY, "b.k2", 4, 2, 3, 1, 7);
    pulse(I_KEY, "b.k3", 4, 3, 3, 2, 7);
    pulse(I_LIGHT, "b.light", 4, 3, 3, 3, 7);
    pulse(I_HIT, "b.h1", 4, 3, 2, 3, 7);
    idle(9);
    pulse(I_HIT, "b.h2", 4, 3, 1, 3, 7);
    idle(9);
    pulse(I_HIT | I_DOOR, "fatal_door", 8, 3, 0, 0, 7);
    pulse(I_RETRY | I_BACK, "retry_prio", 4, 0, 3, 1, 7);

    // Non-fatal hit with door applies both
    pulse(I_KEY, "c.k1", 4, 1, 3, 1, 7);
    pulse(I_KEY, "c.k2", 4, 2, 3, 1, 7);
    pulse(I_KEY, "c.k3", 4, 3, 3, 2, 7);
    pulse(I_LIGHT, "c.light", 4, 3, 3, 3, 7);
    pulse(I_HIT | I_DOOR, "hit_door", 5, 3, 2, 0, 15);
    pulse(I_NEXT, "next2", 6, 0, 3, 1, 15);
    pulse(I_KEY, "s3.key", 6, 1, 3, 1, 15);
    pulse(I_BACK | I_KEY, "abort", 0, 0, 3, 0, 15);
    pulse(I_SEL | (11'd3 << 9), "sel3", 6, 0, 3, 1, 15);
    pulse(I_KEY, "s3.key2", 6, 1, 3, 1, 15);

    // Asynchronous reset mid-stage, away from any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    expect5("async_rst", 0, 0, 3, 0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(I_SEL | (11'd3 << 9), "relock3", 0, 0, 3, 0, 3);

    for (int n = 0; n < 4000; n++) begin
      in_t r;
      r = '0;
      r.sel    = 2'($urandom_range(0, 3));
      r.bsel   = ($urandom_range(0, 99) < 10);
      r.bnext  = ($urandom_range(0, 99) < 8);
      r.bback  = ($urandom_range(0, 99) < 2);
      r.bretry = ($urandom_range(0, 99) < 10);
      r.bstaff = ($urandom_range(0, 99) < 3) && !r.bsel;
      r.key    = ($urandom_range(0, 99) < 15);
      r.light  = ($urandom_range(0, 99) < 10);
      r.door   = ($urandom_range(0, 99) < 10);
      r.hit    = ($urandom_range(0, 99) < 4);
      if (r.bback) r.bnext = 1'b0;
      cyc(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game-flow controller.
- Sits directly upstream of the UI/overlay renderer and owns every piece of game status that renderer draws: `state`, `key_find`, `heart`, `todo`, `play_valid`.
- Consumes one-cycle button pulses from the input decoder and one-cycle gameplay event pulses from the map/collision logic.
- Sequences title, staff, three stages, success screens and fail screen.

Parameters:
- KEYS_NEEDED, 3, keys to collect per stage; range 1..3.
- START_HEART, 3, lives loaded on stage entry; range 1..3.
- INV_CYCLES, 25000000, hit-invulnerability window in clk cycles; counter width 25 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_stage  in  2  stage chosen on title screen; sampled only when btn_sel=1; 0 means none.
- btn_sel  in  1  one-cycle pulse, title select.
- btn_next  in  1  one-cycle pulse.
- btn_back  in  1  one-cycle pulse.
- btn_retry  in  1  one-cycle pulse.
- btn_staff  in  1  one-cycle pulse.
- key_pick  in  1  one-cycle pulse, player touched a key.
- light_pick  in  1  one-cycle pulse, player touched the light.
- door_reach  in  1  one-cycle pulse, player at exit door.
- hit  in  1  one-cycle pulse, player damaged.
- state  out  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
- key_find  out  2  keys collected in current stage.
- heart  out  2  lives remaining.
- todo  out  2  NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3.
- play_valid  out  4  stage unlock mask; bit k = stage k selectable; bits 0,1 always 1.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (rst_n).
  - All outputs are registered and update on the clk edge after the input pulse: latency 1 cycle.
- Reset values: state=TITLE, key_find=0, heart=START_HEART, todo=NONE, play_valid=4'b0011. Internal last_stage=STAGE1, inv_cnt=0.
- TITLE:
  - btn_sel with sel_stage=k (1..3) and play_valid[k]=1 -> enter STAGEk.
  - Locked stage or sel_stage=0 -> stay in TITLE.
  - btn_staff -> STAFF.
  - btn_sel has priority over btn_staff.
- STAFF: btn_back -> TITLE.
- Stage entry, any path: key_find=0, heart=START_HEART, todo=FIND_KEY, inv_cnt=0, last_stage=that stage.
- Inside STAGEk:
  - key_pick while todo==FIND_KEY -> key_find+1. On reaching KEYS_NEEDED, todo=FIND_LIGHT the same edge.
  - key_find never exceeds KEYS_NEEDED; extra key_pick is ignored.
  - light_pick while todo==FIND_LIGHT -> todo=FIND_DOOR; otherwise ignored.
  - door_reach while todo==FIND_DOOR -> SUCCESSk; otherwise ignored.
  - Qualification uses the registered todo, so a key and a light in the same cycle count only the key.
  - hit while inv_cnt==0 -> heart-1 and inv_cnt=INV_CYCLES-1.
  - hit while inv_cnt!=0 -> ignored.
  - inv_cnt decrements to 0 each cycle and saturates at 0.
  - A hit that brings heart to 0 -> FAIL, with priority over a same-cycle door_reach.
  - A non-fatal hit coincident with door_reach applies both: heart-1 and SUCCESSk.
  - btn_back -> TITLE (abort); it has the highest priority in stages.
- Success screens:
  - Entering SUCCESS1 sets play_valid[2]; entering SUCCESS2 sets play_valid[3]. Set bits persist until reset.
  - In SUCCESSk, todo=NONE and key_find/heart hold their final values for display.
  - btn_next: SUCCESS1 -> STAGE2, SUCCESS2 -> STAGE3, SUCCESS3 -> STAFF.
  - btn_back -> TITLE.
- FAIL:
  - heart=0, todo=NONE.
  - btn_retry -> re-enter last_stage with a full entry reset.
  - btn_back -> TITLE.
  - btn_retry has priority over btn_back.
- In TITLE and STAFF: todo=NONE, key_find=0, heart=START_HEART.
- Gameplay pulses outside STAGEk states are ignored.
- Unused state encodings 9..15 -> TITLE on the next edge.
- Reset mid-stage: immediate return to reset values, and play_valid is cleared back to 4'b0011.

Test Plan:
1. Reset, then btn_sel with sel_stage=2 -> state stays 0. btn_sel with sel_stage=1 -> state=2, heart=3, todo=1, key_find=0.
2. In STAGE1, three key_pick pulses 10 cycles apart -> key_find 1,2,3 and todo=2 after the third; a 4th key_pick leaves key_find=3. Then light_pick -> todo=3; door_reach -> state=3, play_valid=4'b0111, todo=0.
3. INV_CYCLES=8: hit at t0 and t0+4 -> heart 3->2 only. Hit at t0+8 -> heart=1.
4. Two more hits spaced >8 cycles -> heart=0, state=8. btn_retry -> state=2, heart=3, key_find=0.
5. Fatal hit in the same cycle as door_reach with todo=3 -> state=8, not 3. From SUCCESS2, btn_next -> state=6; btn_back mid-stage -> state=0 with play_valid=4'b1111 retained.
6. Assert rst_n low mid-STAGE3 with no clk edge -> outputs return to reset values asynchronously, play_valid=4'b0011.
